uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Downstream UART transmitter that consumes the system controller's transmit byte stream.
- Accepts an 8-bit parallel word via a valid/busy handshake.
- Serialises it onto TX_OUT as one UART frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- One bit per CLK cycle. CLK is the divided TX clock, so baud = CLK frequency.

Parameters:
DATA_WIDTH, 8, width of parallel payload; bit counter sized $clog2(DATA_WIDTH).

Ports:
CLK  input  1  TX clock; all state updates on rising edge.
RST  input  1  asynchronous, active-high reset.
P_DATA  input  DATA_WIDTH  byte to transmit; sampled only on accept.
Data_Valid  input  1  request to send P_DATA.
PAR_EN  input  1  1 = insert parity bit; sampled on accept.
PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
TX_OUT  output  1  serial line, idle high.
Busy  output  1  high while a frame is in flight; upstream must hold off.

Behaviour:
- Reset (async, RST=1): TX_OUT=1, Busy=0, state=IDLE, shift register=0, bit counter=0. Any in-flight frame is aborted immediately; no partial stop bit is sent.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: state==IDLE && Data_Valid==1 at a rising edge.
  - On accept, latch P_DATA, PAR_EN and PAR_TYP; next state is START.
  - Data_Valid is ignored in every other state; there is no queuing.
- All outputs are registered, taking the value of the state they belong to.
  - Edge k accepts the byte.
  - From edge k+1: TX_OUT=0 (start bit), Busy=1.
- START: 1 cycle, TX_OUT=0 -> DATA; counter=0.
- DATA: DATA_WIDTH cycles.
  - TX_OUT = latched bit[counter], LSB first; counter increments each cycle.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN, else STOP.
- PARITY: 1 cycle.
  - TX_OUT = ^data when PAR_TYP=0 (even).
  - TX_OUT = ~^data when PAR_TYP=1 (odd).
  - Parity is computed from the latched byte, never live P_DATA.
- STOP: 1 cycle, TX_OUT=1 -> IDLE.
- Busy: 1 from the START cycle through the STOP cycle inclusive; 0 in IDLE.
  - Busy falls on the edge after STOP.
  - Frame length with parity off: 10 cycles of Busy=1.
  - Frame length with parity on: 11 cycles of Busy=1.
- Back-to-back frames: the earliest next accept is the first IDLE cycle. Minimum one idle-high cycle between frames; the next start bit follows that cycle.
- Data_Valid held high continuously: a new frame starts every 11 (parity off) or 12 (parity on) cycles. Each frame carries P_DATA as sampled at its own accept edge.
- P_DATA, PAR_EN or PAR_TYP changing mid-frame: no effect on the current frame.
- Data_Valid asserted together with RST: reset wins; no accept.
- RST deasserted mid-cycle: first accept possible on the first rising edge with RST=0.
- Counter wrap: the counter never exceeds DATA_WIDTH-1. The DATA exit is decoded on counter==DATA_WIDTH-1; no wrap-around is used.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - constants START_BIT=1'b0 and STOP_BIT=1'b1.
- One sub-module is natural: uart_tx_serializer. It contains the latch register, bit counter, current-bit output and done flag, with load/shift enables driven by the FSM.
- Parity and the output mux stay in the top-level uart_tx_frame.

Test Plan:
1. Reset mid-frame: assert RST during DATA bit 3 -> TX_OUT=1 and Busy=0 within the same cycle, asynchronously. After release, a fresh accept of 0x3C produces a complete, correct frame.
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle Data_Valid pulse:
   - TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (start, data, even parity 0, stop);
   - Busy=1 for exactly 11 cycles;
   - TX_OUT=1 afterwards.
3. P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit 0. Same byte with PAR_TYP=0 -> parity bit 1.
4. P_DATA=0xFF, PAR_EN=0 -> TX_OUT 0,1,1,1,1,1,1,1,1,1; Busy high for 10 cycles; no parity cycle.
5. Busy-ignore and back-to-back:
   - Data_Valid held high with P_DATA=0x55 at the first accept, then changed to 0xAA mid-frame.
   - Required: the first frame carries 0x55, with exactly one idle-high cycle after its stop bit.
   - Required: the second frame carries 0xAA; no byte is lost or duplicated.
6. Change PAR_EN 1->0 during DATA bit 5 of a parity-on frame -> the PARITY cycle is still emitted, and the frame remains 11 cycles long.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART transmit state encoding and line-level constants.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] tx_state_t;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : Payload latch and bit counter; presents the bit for the next cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_next_bit,
    output logic                  o_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;

    assign o_done = (r_cnt == c_LAST);

    // Counter saturates on the last bit so it can never index past the payload.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_load) begin
            w_cnt_next = '0;
        end else if (i_shift && !o_done) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // Output is registered one level up, so it needs the bit for the coming cycle.
    assign o_next_bit = r_data[w_cnt_next];
    assign o_data     = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_load) begin
                r_data <= i_data;
            end
            r_cnt <= w_cnt_next;
        end
    end

endmodule : uart_tx_serializer
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : UART frame transmitter, one bit per CLK: start, data LSB first,
//            optional parity, stop. TX_OUT and Busy are registered.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_tx;
    logic                  r_busy;
    logic                  w_accept;
    logic                  w_tx_next;
    logic                  w_parity;
    logic                  w_next_bit;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_accept = (r_state == IDLE) && Data_Valid;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (w_accept),
        .i_shift    (r_state == DATA),
        .i_data     (P_DATA),
        .o_data     (w_data),
        .o_next_bit (w_next_bit),
        .o_done     (w_done)
    );

    assign w_parity = (r_par_typ == PAR_ODD) ? ~^w_data : ^w_data;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (Data_Valid) w_state_next = START;
            START:   w_state_next = DATA;
            DATA:    if (w_done) w_state_next = r_par_en ? PARITY : STOP;
            PARITY:  w_state_next = STOP;
            STOP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they line up with it.
    always_comb begin
        w_tx_next = STOP_BIT;
        case (w_state_next)
            START:   w_tx_next = START_BIT;
            DATA:    w_tx_next = w_next_bit;
            PARITY:  w_tx_next = w_parity;
            default: w_tx_next = STOP_BIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_par_en  <= 1'b0;
            r_par_typ <= PAR_EVEN;
            r_tx      <= STOP_BIT;
            r_busy    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
            end
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule : uart_tx_frame
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Self-checking bench for uart_tx_frame against a queue-based
//            line model, with directed frames and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       Busy;

    int n_cmp = 0;
    int n_err = 0;

    // Line model: queue of bits still to appear on the wire.
    logic mq[$];
    logic m_tx   = 1'b1;
    logic m_busy = 1'b0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_tx   = 1'b1;
        m_busy = 1'b0;
    endtask

    // One clock: advance the model with the inputs present at the edge, check on the falling edge.
    task automatic step();
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else begin
            if (!m_busy && Data_Valid) begin
                mq.push_back(1'b0);
                for (int i = 0; i < 8; i++) mq.push_back(P_DATA[i]);
                if (PAR_EN) mq.push_back(PAR_TYP ? ~(^P_DATA) : (^P_DATA));
                mq.push_back(1'b1);
            end
            if (mq.size() > 0) begin
                m_tx   = mq.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
        end
        @(negedge CLK);
        check_val("tx_line", {31'd0, TX_OUT}, {31'd0, m_tx});
        check_val("busy", {31'd0, Busy}, {31'd0, m_busy});
    endtask

    // Pulse Data_Valid once, then flip every input for the rest of the frame.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             output int busy_cnt, output logic [31:0] bits);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        busy_cnt   = 0;
        bits       = '0;
        for (int i = 0; i < 20 && Busy; i++) begin
            bits[busy_cnt] = TX_OUT;
            busy_cnt++;
            step();
        end
        if (Busy) check_val("frame_timeout", 32'd1, 32'd0);
        check_val("idle_after_frame", {31'd0, TX_OUT}, 32'd1);
    endtask

    initial begin
        int          cnt;
        logic [31:0] bits;
        logic [31:0] exp_bits;
        logic [21:0] tx_hist;
        logic [21:0] busy_hist;
        logic [7:0]  d;
        logic        pe, pt, par;

        // Reset state
        @(negedge CLK);
        check_val("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check_val("reset_busy", {31'd0, Busy}, 32'd0);
        RST = 1'b0;
        model_reset();
        step();

        // Reset mid-frame during data bit 3, with Data_Valid high under reset
        P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        repeat (4) step();
        #2 RST = 1'b1;
        #1;
        check_val("async_rst_tx", {31'd0, TX_OUT}, 32'd1);
        check_val("async_rst_busy", {31'd0, Busy}, 32'd0);
        model_reset();
        Data_Valid = 1'b1;
        step();
        RST = 1'b0;
        Data_Valid = 1'b0;
        step();
        run_frame(8'h3C, 1'b1, 1'b0, cnt, bits);
        check_val("rst_then_3c_bits", bits, 32'({1'b1, 1'b0, 8'h3C, 1'b0}));
        check_val("rst_then_3c_len", cnt, 32'd11);

        // 0xA5 with even parity
        run_frame(8'hA5, 1'b1, 1'b0, cnt, bits);
        check_val("a5_bits", bits, 32'h54A);
        check_val("a5_len", cnt, 32'd11);

        // 0x01 odd then even parity
        run_frame(8'h01, 1'b1, 1'b1, cnt, bits);
        check_val("01_odd_par", {31'd0, bits[9]}, 32'd0);
        run_frame(8'h01, 1'b1, 1'b0, cnt, bits);
        check_val("01_even_par", {31'd0, bits[9]}, 32'd1);

        // 0xFF without parity
        run_frame(8'hFF, 1'b0, 1'b0, cnt, bits);
        check_val("ff_bits", bits, 32'h3FE);
        check_val("ff_len", cnt, 32'd10);

        // Back-to-back with Data_Valid held; payload changes mid-frame
        step();
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            step();
            tx_hist[i]   = TX_OUT;
            busy_hist[i] = Busy;
            if (i == 4)  P_DATA = 8'hAA;
            if (i == 11) Data_Valid = 1'b0;
        end
        check_val("b2b_tx", 32'(tx_hist), 32'({1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0}));
        check_val("b2b_busy", 32'(busy_hist), 32'({1'b0, 10'h3FF, 1'b0, 10'h3FF}));

        // Randomized frames with random idle gaps
        for (int n = 0; n < 30; n++) begin
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            repeat ($urandom_range(0, 3)) step();
            run_frame(d, pe, pt, cnt, bits);
            par = pt ? ~(^d) : (^d);
            exp_bits = pe ? 32'({1'b1, par, d, 1'b0}) : 32'({1'b1, d, 1'b0});
            check_val("rand_bits", bits, exp_bits);
            check_val("rand_len", cnt, pe ? 32'd11 : 32'd10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_uart_tx_frame
`default_nettype wire
